pkt_tx_engine: RTL and testbench
================================

Name: pkt_tx_engine

Overview:
- Transmit side of the NetFPGA-style 64-bit packet datapath (`out_data`/`out_ctrl`/`out_wr`/`out_rdy`).
- On command, streams a packet already stored in a 64-bit packet memory onto the datapath under downstream backpressure.
- Tags word 0 with the module-header ctrl and the final word with the one-hot last-byte ctrl.
- Sits between a processing core's packet memory (1-cycle registered read port) and the output queues.

Parameters:
- DATA_WIDTH, 64, datapath width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width (one bit per byte).
- ADDR_W, 8, packet memory word-address width.
- BUF_DEPTH, 4, prefetch buffer entries (power of 2, >=4).
- FIRST_CTRL, 8'hFF, ctrl value attached to word 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- start_addr  in  ADDR_W  word address of word 0.
- start_len  in  ADDR_W+1  packet length in words; legal range 2..2**ADDR_W.
- last_bytes  in  3  valid bytes in final word; 0 means 8.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the final word is written.
- start_err  out  1  one-cycle pulse when start is rejected.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- out_data  out  DATA_WIDTH  datapath word.
- out_ctrl  out  CTRL_WIDTH  datapath ctrl.
- out_wr  out  1  datapath write strobe.
- out_rdy  in  1  downstream can accept a word this cycle.

Behaviour:
- Reset: clk only; reset is synchronous, active-high. All outputs are 0, state = IDLE, buffer is flushed, and the in-flight read-valid flag is cleared. Reset mid-packet aborts immediately: no done pulse, and returning read data is discarded.
- States: IDLE, FETCH, DRAIN, DONE.
  - IDLE -> FETCH on start with 2 <= start_len <= 2**ADDR_W. Latch start_addr, start_len and last_bytes; clear issue and word counters.
  - IDLE: start with start_len < 2 or start_len > 2**ADDR_W stays in IDLE and pulses start_err in the next cycle.
  - start while not IDLE is ignored, with no start_err.
  - FETCH -> DRAIN in the cycle the final read issues.
  - DRAIN -> DONE when the buffer is empty and no read is in flight.
  - DONE: done=1 for one cycle, then IDLE.
- Read issue, in FETCH: mem_rd_en=1 when (buffer count + in-flight) < BUF_DEPTH; it does not depend on same-cycle out_rdy.
  - mem_rd_addr = latched addr + issue index, mod 2**ADDR_W; wrap-around is legal.
- Ctrl tag is computed at issue and piped with the read:
  - index 0 -> FIRST_CTRL;
  - index len-1 -> one-hot, where last_bytes n=1..7 gives bit (8-n) and n=0 gives 8'h01;
  - otherwise 8'h00.
- The tagged word `{ctrl, mem_rd_data}` is pushed into the buffer in the cycle the data is valid.
- Output:
  - out_data and out_ctrl present the buffer head combinationally, and 0 when the buffer is empty.
  - out_wr = busy & !empty & out_rdy. A pop occurs when out_wr=1.
  - out_wr is never high when out_rdy is low.
- Latency: start in cycle 0 -> first mem_rd_en in cycle 1 -> first out_wr in cycle 3 (out_rdy held high).
- Throughput: 1 word/cycle sustained with out_rdy high.
- done occurs 1 cycle after the final out_wr.
- Buffer never overflows (guaranteed by the issue credit). Simultaneous push and pop is legal at any occupancy.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/FETCH/DRAIN/DONE);
  - FIRST_CTRL default;
  - the last-bytes -> one-hot ctrl function (also used by the receive side for byte counting).
- One sub-module: pkt_tx_fifo.
  - Synchronous fall-through FIFO, BUF_DEPTH x (CTRL_WIDTH+DATA_WIDTH).
  - Outputs: count, empty and head.
  - Flushed by reset.

Test Plan:
- Basic send: start_addr=0x10, start_len=4, last_bytes=3, memory word k = 64'hA0+k, out_rdy=1 -> 4 out_wr in cycles 3..6 with data A0..A3 and ctrl FF,00,00,20; done in cycle 7.
- Wrap: start_addr=0xFE, len=4 -> read addresses FE,FF,00,01; data order preserved; last_bytes=0 gives last ctrl 01.
- Backpressure: len=8, out_rdy toggles 1,0,0,1,... -> no out_wr while out_rdy=0; 8 words in order; mem_rd_en never raised with count+in-flight=4.
- Rejects: start_len=1 -> start_err pulse, busy stays 0. start during busy -> ignored; current packet completes unchanged.
- Reset mid-packet: reset asserted after 2 of 6 words -> next cycle all outputs 0, IDLE. A fresh start with len=2 then emits exactly 2 words (FF,last).
- Max length: len=256, out_rdy=1 -> 256 consecutive out_wr, one done pulse.

Source files
------------

// File: rtl/pkt_tx_engine_pkg.sv
// Shared types and helpers for the 64-bit packet transmit/receive datapath.
// Holds the engine state encoding, the word-0 ctrl default and the last-byte ctrl encoder.
package pkt_tx_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] FIRST_CTRL_DFLT = 8'hFF;

  // n valid bytes in the final word -> one-hot marker of the last valid byte; 0 means all 8.
  function automatic logic [7:0] last_ctrl(input logic [2:0] n);
    if (n == 3'd0) return 8'h01;
    return 8'h01 << (4'd8 - {1'b0, n});
  endfunction

endpackage

// File: rtl/pkt_tx_fifo.sv
// Purpose: fall-through FIFO holding tagged words between the memory read port and the datapath.
// Latency: a push is visible at head the cycle after; pop takes effect at the clock edge.
// Backpressure: none internally; the writer must respect count (no full flag).
module pkt_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/pkt_tx_engine.sv
// Purpose: streams a stored packet from packet memory onto the 64-bit datapath with ctrl tagging.
// Latency: start -> first read 1 cycle -> first out_wr 3 cycles; 1 word/cycle sustained.
// Backpressure: out_rdy gates out_wr; reads are credit-limited so the prefetch buffer never overflows.
module pkt_tx_engine
  import pkt_tx_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_W     = 8,
  parameter int BUF_DEPTH  = 4,
  parameter logic [CTRL_WIDTH-1:0] FIRST_CTRL = CTRL_WIDTH'(FIRST_CTRL_DFLT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W:0]       start_len,
  input  logic [2:0]            last_bytes,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy
);

  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int LEN_W   = ADDR_W + 1;
  localparam int MAX_LEN = 2 ** ADDR_W;

  state_t                state;
  logic [ADDR_W-1:0]     addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [2:0]            lbytes_q;
  logic [LEN_W-1:0]      issue_idx;
  logic                  rd_vld;
  logic [CTRL_WIDTH-1:0] rd_ctrl;
  logic [CTRL_WIDTH-1:0] issue_ctrl;

  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]                 fifo_count;
  logic                             fifo_empty;
  logic [CNT_W:0]                   occupancy;
  logic                             len_ok;
  logic                             last_issue;

  assign len_ok     = (start_len >= LEN_W'(2)) && (start_len <= LEN_W'(MAX_LEN));
  assign last_issue = (issue_idx == len_q - LEN_W'(1));

  // Words buffered plus the read still in flight; each issued read reserves its buffer slot.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_vld};
  assign mem_rd_en = (state == ST_FETCH) && (occupancy < (CNT_W+1)'(BUF_DEPTH));
  assign mem_rd_addr = mem_rd_en ? (addr_q + issue_idx[ADDR_W-1:0]) : '0;

  always_comb begin
    issue_ctrl = '0;
    if (issue_idx == '0)
      issue_ctrl = FIRST_CTRL;
    else if (last_issue)
      issue_ctrl = CTRL_WIDTH'(last_ctrl(lbytes_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      lbytes_q  <= '0;
      issue_idx <= '0;
      rd_vld    <= 1'b0;
      rd_ctrl   <= '0;
      start_err <= 1'b0;
    end else begin
      start_err <= 1'b0;
      rd_vld    <= mem_rd_en;
      if (mem_rd_en) begin
        rd_ctrl   <= issue_ctrl;
        issue_idx <= issue_idx + LEN_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len_ok) begin
              state     <= ST_FETCH;
              addr_q    <= start_addr;
              len_q     <= start_len;
              lbytes_q  <= last_bytes;
              issue_idx <= '0;
            end else begin
              start_err <= 1'b1;
            end
          end
        end
        ST_FETCH: if (mem_rd_en && last_issue) state <= ST_DRAIN;
        // Leave on the edge the buffer goes empty so done lands one cycle after the last write.
        ST_DRAIN: if (!rd_vld && (fifo_count == {{(CNT_W-1){1'b0}}, out_wr})) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  pkt_tx_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (CTRL_WIDTH + DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rd_vld),
    .push_dat ({rd_ctrl, mem_rd_data}),
    .pop      (out_wr),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign out_wr   = busy && !fifo_empty && out_rdy;
  assign out_data = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign out_ctrl = fifo_empty ? '0 : fifo_head[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_pkt_tx_engine.sv
// Directed bench for pkt_tx_engine: packet-level model compared every cycle plus literal anchors.
module tb_pkt_tx_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic [8:0]  start_len = '0;
  logic [2:0]  last_bytes = '0;
  logic        busy, done, start_err, mem_rd_en, out_wr;
  logic [7:0]  mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_rdy = 1'b0;

  always #5 clk = ~clk;

  pkt_tx_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .start_len   (start_len),
    .last_bytes  (last_bytes),
    .busy        (busy),
    .done        (done),
    .start_err   (start_err),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_ctrl    (out_ctrl),
    .out_wr      (out_wr),
    .out_rdy     (out_rdy)
  );

  // Packet memory with a one-cycle registered read port.
  logic [63:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 64'h90 + 64'(i);
  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Packet-level model
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int          m_len = 0, m_issued = 0, m_written = 0;
  int          m_addr = 0;
  logic [71:0] expq[$];

  int          wr_cyc[$];
  logic [71:0] wr_word[$];
  logic [7:0]  rd_log[$];
  int          done_cyc[$];
  int          err_cyc[$];

  always @(negedge clk) begin
    if (chk_en) begin
      bit nd, legal, acc, nb, ne;
      logic [7:0] ctl;
      nd = 1'b0;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("start_err", start_err, m_err);
      if (done) done_cyc.push_back(cyc);
      if (start_err) err_cyc.push_back(cyc);
      if (!out_rdy) chk("out_wr_while_not_rdy", out_wr, 1'b0);
      if (!m_busy)
        chk("idle_outputs", {mem_rd_en, out_wr, mem_rd_addr, out_ctrl, out_data}, '0);
      if (mem_rd_en) begin
        chk("rd_within_packet", m_busy && (m_issued < m_len), 1'b1);
        chk("rd_addr", mem_rd_addr, (m_addr + m_issued) % 256);
        chk("rd_credit", (m_issued - m_written) < 4, 1'b1);
        rd_log.push_back(mem_rd_addr);
        m_issued++;
      end
      if (out_wr) begin
        wr_cyc.push_back(cyc);
        wr_word.push_back({out_ctrl, out_data});
        chk("wr_pending", expq.size() > 0, 1'b1);
        if (expq.size() > 0) chk("wr_word", {out_ctrl, out_data}, expq.pop_front());
        m_written++;
        if (m_busy && m_written == m_len) nd = 1'b1;
      end
      legal = (start_len >= 2) && (start_len <= 256);
      acc   = start && !m_busy && legal;
      ne    = start && !m_busy && !legal;
      nb    = acc || (m_busy && !m_done);
      if (reset) begin
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        expq.delete();
      end else begin
        m_busy = nb; m_done = nd; m_err = ne;
        if (acc) begin
          m_len = int'(start_len); m_addr = int'(start_addr);
          m_issued = 0; m_written = 0;
          for (int k = 0; k < m_len; k++) begin
            if (k == 0) ctl = 8'hFF;
            else if (k == m_len - 1) ctl = (last_bytes == 3'd0) ? 8'h01 : (8'h80 >> (last_bytes - 3'd1));
            else ctl = 8'h00;
            expq.push_back({ctl, mem[(m_addr + k) % 256]});
          end
        end
      end
    end
  end

  task automatic clear_logs();
    wr_cyc.delete(); wr_word.delete(); rd_log.delete(); done_cyc.delete(); err_cyc.delete();
  endtask

  task automatic send(input logic [7:0] a, input logic [8:0] l, input logic [2:0] lb, output int s);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; start_len = l; last_bytes = lb; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input int budget, input bit bp);
    int d0;
    bit got;
    d0 = done_cyc.size();
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      out_rdy = bp ? ((cyc % 3) == 0) : 1'b1;
      @(negedge clk); #1;
      if (done_cyc.size() != d0) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    chk("done_seen", got, 1'b1);
  endtask

  logic [7:0] basic_ctl [4] = '{8'hFF, 8'h00, 8'h00, 8'h20};
  logic [7:0] wrap_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    int s, s2;
    bit got;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, start_err, mem_rd_en, out_wr, mem_rd_addr, out_ctrl, out_data}, '0);
    @(posedge clk); #1;
    reset = 1'b0; chk_en = 1'b1; out_rdy = 1'b1;

    // Basic send
    clear_logs();
    send(8'h10, 9'd4, 3'd3, s);
    run(30, 1'b0);
    chk("basic_count", wr_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_cycle", wr_cyc[i], s + 3 + i);
      chk("basic_word", wr_word[i], {basic_ctl[i], 64'hA0 + 64'(i)});
    end
    chk("basic_done_cycle", done_cyc[0], s + 7);

    // Address wrap, last_bytes=0
    clear_logs();
    send(8'hFE, 9'd4, 3'd0, s);
    run(30, 1'b0);
    chk("wrap_rd_count", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("wrap_rd_addr", rd_log[i], wrap_addr[i]);
    chk("wrap_first", wr_word[0], {8'hFF, 64'h18E});
    chk("wrap_last", wr_word[3], {8'h01, 64'h91});

    // Backpressure 1,0,0 pattern
    clear_logs();
    send(8'h20, 9'd8, 3'd5, s);
    run(100, 1'b1);
    chk("bp_count", wr_cyc.size(), 8);
    for (int i = 0; i < 8; i++) chk("bp_data", wr_word[i][63:0], 64'hB0 + 64'(i));

    // Rejected lengths
    clear_logs();
    send(8'h00, 9'd1, 3'd0, s);
    repeat (3) @(posedge clk);
    #1;
    chk("rej_err_count", err_cyc.size(), 1);
    chk("rej_err_cycle", err_cyc[0], s + 1);
    send(8'h00, 9'd0, 3'd0, s);
    send(8'h00, 9'd257, 3'd0, s);
    repeat (3) @(posedge clk);
    #1;
    chk("rej_err_total", err_cyc.size(), 3);
    chk("rej_no_write", wr_cyc.size(), 0);

    // Start while busy is ignored
    clear_logs();
    send(8'h10, 9'd4, 3'd3, s);
    send(8'h40, 9'd2, 3'd1, s2);
    run(30, 1'b0);
    chk("ign_count", wr_cyc.size(), 4);
    for (int i = 0; i < 4; i++) chk("ign_word", wr_word[i], {basic_ctl[i], 64'hA0 + 64'(i)});
    chk("ign_no_err", err_cyc.size(), 0);

    // Reset mid-packet
    clear_logs();
    send(8'h30, 9'd6, 3'd2, s);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (wr_cyc.size() >= 2) begin got = 1'b1; break; end
    end
    chk("rst_two_words", got, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; out_rdy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; out_rdy = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {busy, done, start_err, mem_rd_en, out_wr, mem_rd_addr, out_ctrl, out_data}, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_words_kept", wr_cyc.size(), 2);
    chk("rst_no_done", done_cyc.size(), 0);
    clear_logs();
    send(8'h50, 9'd2, 3'd5, s);
    run(30, 1'b0);
    chk("rst_fresh_count", wr_cyc.size(), 2);
    chk("rst_fresh_w0", wr_word[0], {8'hFF, 64'hE0});
    chk("rst_fresh_w1", wr_word[1], {8'h08, 64'hE1});

    // Maximum length
    clear_logs();
    send(8'h00, 9'd256, 3'd1, s);
    run(400, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("max_count", wr_cyc.size(), 256);
    chk("max_first_cycle", wr_cyc[0], s + 3);
    chk("max_contiguous", wr_cyc[255] - wr_cyc[0], 255);
    chk("max_last_ctrl", wr_word[255][71:64], 8'h80);
    chk("max_one_done", done_cyc.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
